// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter for a single n-bit resource port; winner payload is muxed, registered and held until completion.
// Optional build macro ARB_TIMEOUT_EN adds a TO_W-bit BUSY watchdog that aborts a stalled transaction with err.
//
// state | meaning
// IDLE  | no owner, arbitrating between req_a / req_b
// BUSY  | payload presented to the resource, waiting for res_done
// ACK   | one-cycle completion pulse to the owner, no new grant

module mux2_n #(
    parameter int n = 32
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         sel_i,
    output logic [n-1:0] f_o
);

    assign f_o = sel_i ? b_i : a_i;

endmodule

module mux2_arbiter #(
    parameter int n    = 32,
    parameter int TO_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         res_done,
    output logic [n-1:0] F,
    output logic         sel,
    output logic         res_valid,
    output logic         ack_a,
    output logic         ack_b,
    output logic         err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_t;

    state_t       state_q;
    logic         last_q;
    logic [n-1:0] f_q;
    logic         sel_q;
    logic         valid_q;
    logic         ack_a_q;
    logic         ack_b_q;

    logic         grant_d;
    logic         grant_b_d;
    logic [n-1:0] f_d;
    logic         abort_d;

    // On contention B wins only if A was served last.
    assign grant_d   = req_a | req_b;
    assign grant_b_d = req_b & (~req_a | ~last_q);

    mux2_n #(.n(n)) u_mux (
        .a_i   (A),
        .b_i   (B),
        .sel_i (grant_b_d),
        .f_o   (f_d)
    );

`ifdef ARB_TIMEOUT_EN
    // Abort on the BUSY cycle where the count would step to all-ones.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

    logic [TO_W-1:0] cnt_q;
    logic            err_q;

    assign abort_d = (cnt_q == TO_LAST) && !res_done;
    assign err     = err_q;
`else
    logic unused_to_w;

    assign abort_d     = 1'b0;
    assign err         = 1'b0;
    assign unused_to_w = (TO_W > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            f_q     <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    if (grant_d) begin
                        sel_q   <= grant_b_d;
                        f_q     <= f_d;
                        last_q  <= grant_b_d;
                        valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (res_done || abort_d) begin
                        valid_q <= 1'b0;
                        ack_a_q <= ~sel_q;
                        ack_b_q <= sel_q;
`ifdef ARB_TIMEOUT_EN
                        err_q   <= abort_d;
`endif
                        state_q <= ST_ACK;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= cnt_q + TO_W'(1);
`endif
                    end
                end
                ST_ACK: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign F         = f_q;
    assign sel       = sel_q;
    assign res_valid = valid_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed stimulus queues expected grants/acks, a negedge monitor pops and compares.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined for the build.

module tb_mux2_arbiter;

    localparam int N  = 32;
    localparam int TW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic         res_done = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] F;
    logic         sel;
    logic         res_valid;
    logic         ack_a;
    logic         ack_b;
    logic         err;

    mux2_arbiter #(.n(N), .TO_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .A         (A),
        .B         (B),
        .res_done  (res_done),
        .F         (F),
        .sel       (sel),
        .res_valid (res_valid),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [N-1:0] f;
    } grant_t;

    typedef struct {
        logic to_b;
        logic err;
        int   busy;
    } ack_t;

    grant_t gq[$];
    ack_t   aq[$];
    longint gcyc[$];

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_F"},         F,                 32'h0);
        chk({tag, "_sel"},       32'(sel),          32'h0);
        chk({tag, "_res_valid"}, 32'(res_valid),    32'h0);
        chk({tag, "_ack_a"},     32'(ack_a),        32'h0);
        chk({tag, "_ack_b"},     32'(ack_b),        32'h0);
        chk({tag, "_err"},       32'(err),          32'h0);
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: res_valid still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (!(ack_a || ack_b) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(ack_a || ack_b)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack after %0d cycles, expected an ack", name, n);
        end
    endtask

    task automatic pulse_done();
        res_done = 1'b1;
        @(posedge clk);
        #1;
        res_done = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    logic   prev_valid = 1'b0;
    logic   prev_ack = 1'b0;
    int     busy_cnt = 0;
    grant_t cur = '{sel: 1'b0, f: '0};
    ack_t   exp_ack;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (res_valid && !prev_valid) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: sel=%0d F=%0h, expected no grant", sel, F);
                end else begin
                    cur = gq.pop_front();
                    chk("grant_sel", 32'(sel), 32'(cur.sel));
                    chk("grant_F", F, cur.f);
                end
                gcyc.push_back(cyc);
                busy_cnt = 0;
            end
            if (res_valid) begin
                busy_cnt++;
                if (F !== cur.f || sel !== cur.sel) begin
                    checks++;
                    errors++;
                    $display("FAIL hold: F=%0h sel=%0d, expected F=%0h sel=%0d", F, sel, cur.f, cur.sel);
                end
            end
            if (ack_a && ack_b) begin
                checks++;
                errors++;
                $display("FAIL ack_both: ack_a=1 ack_b=1, expected at most one");
            end
            if (ack_a || ack_b) begin
                if (prev_ack) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_width: ack high 2 cycles, expected 1");
                end
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: ack_a=%0d ack_b=%0d, expected none", ack_a, ack_b);
                end else begin
                    exp_ack = aq.pop_front();
                    chk("ack_b_owner", 32'(ack_b), 32'(exp_ack.to_b));
                    chk("ack_a_owner", 32'(ack_a), 32'(!exp_ack.to_b));
                    chk("ack_err", 32'(err), 32'(exp_ack.err));
                    chk("ack_res_valid", 32'(res_valid), 32'h0);
                    if (exp_ack.busy >= 0)
                        chk("busy_cycles", 32'(busy_cnt), 32'(exp_ack.busy));
                end
            end else if (err) begin
                checks++;
                errors++;
                $display("FAIL err_without_ack: err=1, expected 0");
            end
            prev_valid = res_valid;
            prev_ack   = ack_a | ack_b;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int gstart;

        #2;
        chk_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request from A, one-cycle ack, no err
        A = 32'h1234_5678;
        req_a = 1'b1;
        gq.push_back('{sel: 1'b0, f: 32'h1234_5678});
        aq.push_back('{to_b: 1'b0, err: 1'b0, busy: 1});
        wait_grant("t1");
        pulse_done();
        chk("t1_ack_a", 32'(ack_a), 32'h1);
        req_a = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_ack_a_cleared", 32'(ack_a), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Payload is captured at grant; later changes to B are ignored
        B = 32'hDEAD_BEEF;
        req_b = 1'b1;
        gq.push_back('{sel: 1'b1, f: 32'hDEAD_BEEF});
        aq.push_back('{to_b: 1'b1, err: 1'b0, busy: 3});
        wait_grant("t3");
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_F_held", F, 32'hDEAD_BEEF);
        pulse_done();
        req_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during BUSY: outputs clear asynchronously, no ack
        A = 32'h0000_0055;
        req_a = 1'b1;
        gq.push_back('{sel: 1'b0, f: 32'h0000_0055});
        wait_grant("t4");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        req_a = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Both held: grants alternate A,B,A,B three cycles apart
        A = 32'hAAAA_0001;
        B = 32'hBBBB_0002;
        gstart = gcyc.size();
        for (int i = 0; i < 4; i++) begin
            gq.push_back('{sel: (i % 2 == 1), f: (i % 2 == 1) ? 32'hBBBB_0002 : 32'hAAAA_0001});
            aq.push_back('{to_b: (i % 2 == 1), err: 1'b0, busy: 1});
        end
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_grant("t2");
            pulse_done();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("t2_grant_count", 32'(gcyc.size() - gstart), 32'd4);
        if (gcyc.size() >= gstart + 4) begin
            for (int i = 0; i < 3; i++)
                chk("t2_grant_gap", 32'(gcyc[gstart + i + 1] - gcyc[gstart + i]), 32'd3);
        end
        repeat (3) @(posedge clk);
        #1;

`ifdef ARB_TIMEOUT_EN
        // Stalled resource: abort after 15 BUSY cycles with err
        A = 32'h0F0F_0F0F;
        req_a = 1'b1;
        gq.push_back('{sel: 1'b0, f: 32'h0F0F_0F0F});
        aq.push_back('{to_b: 1'b0, err: 1'b1, busy: 15});
        wait_grant("t5");
        wait_ack("t5");
        chk("t5_err", 32'(err), 32'h1);
        req_a = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_err_cleared", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // res_done on the terminal BUSY cycle completes normally
        A = 32'h7777_1111;
        req_a = 1'b1;
        gq.push_back('{sel: 1'b0, f: 32'h7777_1111});
        aq.push_back('{to_b: 1'b0, err: 1'b0, busy: 15});
        wait_grant("t6");
        repeat (14) @(posedge clk);
        #1;
        pulse_done();
        chk("t6_ack_a", 32'(ack_a), 32'h1);
        chk("t6_err", 32'(err), 32'h0);
        req_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif

        chk("grant_queue_drained", 32'(gq.size()), 32'h0);
        chk("ack_queue_drained", 32'(aq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
